contador_digito: RTL
====================

# contador_digito

Sequential input stage that feeds the seven-segment decoder. It synchronizes and debounces two push-buttons (up/down) and maintains a modulo-(MAX_VALUE+1) digit counter. The counter value is driven on the decoder's four code lines {D, N3, N2, N1}, with D as the MSB. Single-cycle carry/borrow pulses allow a second digit to be chained.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a level change; range 1..255.
- MAX_VALUE, 9: highest counter value; range 1..15.
- REPEAT_DELAY, 8: cycles from the first step until auto-repeat starts (only with CONTADOR_AUTOREPEAT_EN).
- REPEAT_PERIOD, 4: cycles between repeated steps (only with CONTADOR_AUTOREPEAT_EN).
- clk  input  1  single clock; all state is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- btn_up  input  1  raw up button, asynchronous, active-high.
- btn_down  input  1  raw down button, asynchronous, active-high.
- clr  input  1  synchronous clear of the count, active-high, already synchronous to clk.
- D  output  1  count bit 3 (MSB), registered.
- N3  output  1  count bit 2, registered.
- N2  output  1  count bit 1, registered.
- N1  output  1  count bit 0 (LSB), registered.
- carry  output  1  one-cycle pulse on wrap from MAX_VALUE to 0, registered.
- borrow  output  1  one-cycle pulse on wrap from 0 to MAX_VALUE, registered.

## Operation
- Synchronizer: each button passes through a 2-FF chain. The chains reset to 0.
- Debouncer, per button: an 8-bit counter and a debounced level `deb`.
  - sync == deb: counter <= 0.
  - sync != deb and counter == DEBOUNCE_CYCLES-1: deb <= sync, counter <= 0.
  - Otherwise: counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES samples is discarded.
- Step generation: a rising edge of `deb` (deb=1, previous deb=0) produces a one-cycle step_up or step_down. Falling edges produce nothing.
- Counter update, in priority order each cycle:
  - clr: count <= 0, no carry/borrow.
  - step_up and step_down in the same cycle: no change.
  - step_up: count == MAX_VALUE ? 0 with carry=1 : count+1.
  - step_down: count == 0 ? MAX_VALUE with borrow=1 : count-1.
  - Otherwise: hold.
- Counter arithmetic is 4-bit unsigned. The count never leaves 0..MAX_VALUE. Codes above MAX_VALUE are unreachable and never driven to the decoder.
- carry/borrow are 0 in every cycle where no wrap occurs.
- Reset, including mid-debounce or mid-repeat: all synchronizers, debouncers, repeat timers, the count, carry and borrow return to 0 immediately.
- A button held high through reset release is treated as a new press: it produces a step after the normal latency.

## Timing
- Press latency: btn_up goes high before clk edge k and stays stable. Then sync2=1 after edge k+1, deb=1 after edge k+1+DEBOUNCE_CYCLES, and count/carry update at edge k+2+DEBOUNCE_CYCLES. This is 6 edges with the default parameters.
- Release latency: the same number of edges to clear deb. No output change occurs on release.
- carry/borrow are high for exactly one cycle, coincident with the new count value.
- clr takes effect on the edge where it is sampled high, with 1-cycle latency.
- Outputs hold their reset value (count 0, carry 0, borrow 0) while rst is high.

## Configuration
- CONTADOR_AUTOREPEAT_EN defined:
  - While exactly one debounced button stays high, a first repeat step fires REPEAT_DELAY cycles after the initial step.
  - Further steps then fire every REPEAT_PERIOD cycles until release.
  - Release, an opposite press, or clr resets the repeat timer.
  - Repeat steps wrap and pulse carry/borrow exactly like normal steps.
- Not defined: one step per debounced press. The REPEAT_* parameters are ignored and no repeat timer is synthesized.

## Test plan
- Reset → count 0 (D,N3,N2,N1 = 0000), carry 0, borrow 0. Assert rst mid-debounce → all return to 0 asynchronously, with no step after release if the button is low.
- Ten clean btn_up presses, each held 20 cycles, with defaults → count 1..9, then 0. carry pulses for one cycle only on the 9→0 wrap; each update lands 6 edges after the press.
- btn_down from 0 → count 9 with a one-cycle borrow. btn_down from 5 → count 4, borrow 0.
- btn_up glitch of 3 cycles (DEBOUNCE_CYCLES=4), then bounce 1-0-1 → no step for the glitch. The bounced press produces exactly one step.
- btn_up and btn_down pressed in the same cycle → count unchanged. clr asserted together with step_up at count 7 → count 0, carry 0.
- With CONTADOR_AUTOREPEAT_EN, hold btn_up 40 cycles from count 0 → steps occur at the initial step, +8, +12, +16, ... A wrap at 9→0 pulses carry. Without the macro, the same stimulus → count 1 only.

Source files
------------

// File: rtl/contador_digito.sv
// Button front end for the seven-segment digit: 2-FF sync, debounce, mod-(MAX_VALUE+1) counter with carry/borrow.
// Latency: press to count update is DEBOUNCE_CYCLES+2 edges; no backpressure, every accepted step is applied.
// Optional auto-repeat while one button is held: define CONTADOR_AUTOREPEAT_EN.
module contador_digito #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_VALUE       = 9,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic clr,
  output logic D,
  output logic N3,
  output logic N2,
  output logic N1,
  output logic carry,
  output logic borrow
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MAX_CODE = 4'(MAX_VALUE);

  // Index 0 is the up button, index 1 the down button.
  logic [1:0] btn;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [1:0] deb_q;
  logic [1:0] edge_step;
  logic [1:0] rep_step;
  logic [7:0] deb_cnt [2];
  logic       step_up;
  logic       step_down;
  logic [3:0] count;
  logic [3:0] count_nx;
  logic       carry_nx;
  logic       borrow_nx;

  assign btn = {btn_down, btn_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      deb_q      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign edge_step = deb & ~deb_q;

`ifdef CONTADOR_AUTOREPEAT_EN
  localparam logic [7:0] REP_FIRST = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] REP_NEXT  = 8'(REPEAT_PERIOD - 1);

  logic [7:0] rep_cnt;
  logic       rep_first;
  logic       rep_hold;
  logic       rep_fire;

  // Timer restarts on every fresh press so the first repeat is measured from the initial step.
  assign rep_hold = deb[0] ^ deb[1];
  assign rep_fire = rep_hold && (edge_step == 2'b00) &&
                    (rep_cnt == (rep_first ? REP_FIRST : REP_NEXT));
  assign rep_step = rep_fire ? deb : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (!rep_hold || clr || (edge_step != 2'b00)) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + 8'd1;
    end
  end
`else
  logic unused_repeat;

  assign unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rep_step      = 2'b00;
`endif

  assign step_up   = edge_step[0] | rep_step[0];
  assign step_down = edge_step[1] | rep_step[1];

  always_comb begin
    count_nx  = count;
    carry_nx  = 1'b0;
    borrow_nx = 1'b0;
    if (clr) begin
      count_nx = '0;
    end else if (step_up && step_down) begin
      count_nx = count;
    end else if (step_up) begin
      if (count == MAX_CODE) begin
        count_nx = '0;
        carry_nx = 1'b1;
      end else begin
        count_nx = count + 4'd1;
      end
    end else if (step_down) begin
      if (count == 4'd0) begin
        count_nx  = MAX_CODE;
        borrow_nx = 1'b1;
      end else begin
        count_nx = count - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      count  <= count_nx;
      carry  <= carry_nx;
      borrow <= borrow_nx;
    end
  end

  assign {D, N3, N2, N1} = count;

endmodule
